// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter that merges per-unit results onto one registered
// broadcast bus slot, with full-throughput replace-on-consume.

package result_bus_arbiter_pkg;
  typedef struct packed {
    logic [3:0] cr0;  // lt, gt, eq, so
    logic       so;
    logic       ov;
    logic       ca;
  } cond_exception_t;
endpackage

module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int unsigned UNITS       = 4,
  parameter int unsigned RS_ID_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic            [UNITS-1:0]           unit_valid,
  output logic            [UNITS-1:0]           unit_ready,
  input  logic            [UNITS-1:0][RS_ID_WIDTH-1:0] unit_rs_id,
  input  logic            [UNITS-1:0][4:0]      unit_reg_addr,
  input  logic            [UNITS-1:0][31:0]     unit_result,
  input  cond_exception_t [UNITS-1:0]           unit_cr0_xer,
  output logic                                  bus_valid,
  input  logic                                  bus_ready,
  output logic            [RS_ID_WIDTH-1:0]     bus_rs_id,
  output logic            [4:0]                 bus_reg_addr,
  output logic            [31:0]                bus_result,
  output cond_exception_t                       bus_cr0_xer,
  output logic            [$clog2(UNITS)-1:0]   bus_unit
);

  localparam int unsigned IDX_W = $clog2(UNITS);
  localparam int unsigned CW    = IDX_W + 1;

  logic                   bus_valid_q;
  logic [RS_ID_WIDTH-1:0] bus_rs_id_q;
  logic [4:0]             bus_reg_addr_q;
  logic [31:0]            bus_result_q;
  cond_exception_t        bus_cr0_xer_q;
  logic [IDX_W-1:0]       bus_unit_q;
  logic [IDX_W-1:0]       last_grant_q;

  logic                   slot_free;
  logic                   found;
  logic [IDX_W-1:0]       win;
  logic [CW-1:0]          cand;
  logic [UNITS-1:0]       ready_d;

  assign slot_free = !bus_valid_q || bus_ready;

  // Round-robin search starting just after the last granted unit.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    cand    = '0;
    ready_d = '0;
    for (int off = 0; off < int'(UNITS); off++) begin
      cand = CW'(last_grant_q) + CW'(off) + CW'(1);
      if (cand >= CW'(UNITS)) cand = cand - CW'(UNITS);
      if (!found && unit_valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
    if (found && slot_free && rst) ready_d[win] = 1'b1;
  end

  assign unit_ready = ready_d;

  // Output slot: load on grant, clear on idle consume, hold on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_valid_q    <= 1'b0;
      bus_rs_id_q    <= '0;
      bus_reg_addr_q <= '0;
      bus_result_q   <= '0;
      bus_cr0_xer_q  <= '0;
      bus_unit_q     <= '0;
      last_grant_q   <= IDX_W'(UNITS - 1);
    end else if (slot_free) begin
      if (found) begin
        bus_valid_q    <= 1'b1;
        bus_rs_id_q    <= unit_rs_id[win];
        bus_reg_addr_q <= unit_reg_addr[win];
        bus_result_q   <= unit_result[win];
        bus_cr0_xer_q  <= unit_cr0_xer[win];
        bus_unit_q     <= win;
        last_grant_q   <= win;
      end else begin
        bus_valid_q    <= 1'b0;
      end
    end
  end

  assign bus_valid    = bus_valid_q;
  assign bus_rs_id    = bus_rs_id_q;
  assign bus_reg_addr = bus_reg_addr_q;
  assign bus_result   = bus_result_q;
  assign bus_cr0_xer  = bus_cr0_xer_q;
  assign bus_unit     = bus_unit_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed, table-driven bench for result_bus_arbiter (UNITS=4).

module tb_result_bus_arbiter;
  import result_bus_arbiter_pkg::*;

  logic                        clk;
  logic                        rst;
  logic [3:0]                  unit_valid;
  logic [3:0]                  unit_ready;
  logic [3:0][4:0]             unit_rs_id;
  logic [3:0][4:0]             unit_reg_addr;
  logic [3:0][31:0]            unit_result;
  cond_exception_t [3:0]       unit_cr0_xer;
  logic                        bus_valid;
  logic                        bus_ready;
  logic [4:0]                  bus_rs_id;
  logic [4:0]                  bus_reg_addr;
  logic [31:0]                 bus_result;
  cond_exception_t             bus_cr0_xer;
  logic [1:0]                  bus_unit;

  int n_checks = 0;
  int n_errors = 0;

  result_bus_arbiter #(.UNITS(4), .RS_ID_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .unit_valid(unit_valid), .unit_ready(unit_ready),
    .unit_rs_id(unit_rs_id), .unit_reg_addr(unit_reg_addr),
    .unit_result(unit_result), .unit_cr0_xer(unit_cr0_xer),
    .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_rs_id(bus_rs_id), .bus_reg_addr(bus_reg_addr),
    .bus_result(bus_result), .bus_cr0_xer(bus_cr0_xer),
    .bus_unit(bus_unit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic        ready;
    logic [3:0]  exp_ur;
    logic        exp_bv;
    logic [1:0]  exp_unit;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] res_of(input int u);
    return 32'hA000_0000 | 32'(u);
  endfunction

  function automatic logic [6:0] cx_of(input int u);
    return 7'(u * 5 + 3);
  endfunction

  task automatic default_payload();
    for (int u = 0; u < 4; u++) begin
      unit_result[u]   = res_of(u);
      unit_rs_id[u]    = 5'(u + 1);
      unit_reg_addr[u] = 5'(u + 8);
      unit_cr0_xer[u]  = cx_of(u);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b1;
    unit_valid = '0;
    bus_ready  = 1'b1;
    default_payload();
    #1 rst = 1'b0;
    #2;
    chk("rst_bus_valid", 64'(bus_valid), 64'd0);
    chk("rst_payload", 64'({bus_rs_id, bus_reg_addr, bus_result, 7'(bus_cr0_xer), bus_unit}), 64'd0);
    unit_valid = 4'b1111;
    @(posedge clk); #1;
    chk("rst_ready_zero", 64'(unit_ready), 64'd0);
    chk("rst_hold_valid", 64'(bus_valid), 64'd0);

    // Single requester after reset release, mid-cycle.
    rst = 1'b1;
    unit_valid = 4'b0100;
    unit_result[2] = 32'hDEAD_BEEF;
    unit_rs_id[2] = 5'd3;
    unit_reg_addr[2] = 5'd7;
    #1;
    chk("single_ready", 64'(unit_ready), 64'b0100);
    @(posedge clk); #1;
    unit_valid = '0;
    chk("single_valid", 64'(bus_valid), 64'd1);
    chk("single_result", 64'(bus_result), 64'hDEAD_BEEF);
    chk("single_rs_id", 64'(bus_rs_id), 64'd3);
    chk("single_reg", 64'(bus_reg_addr), 64'd7);
    chk("single_unit", 64'(bus_unit), 64'd2);

    default_payload();
    do_reset();

    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, res_of(0)};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, res_of(1)};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, res_of(2)};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, res_of(3)};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, res_of(0)};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, res_of(1)};
    vecs[6]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1, res_of(1)};
    vecs[7]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1, res_of(1)};
    vecs[8]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1, res_of(1)};
    vecs[9]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, res_of(3)};
    vecs[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, res_of(0)};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, res_of(0)};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, res_of(0)};
    vecs[13] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, res_of(2)};
    vecs[14] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd2, res_of(2)};
    vecs[15] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, res_of(1)};
    vecs[16] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2, res_of(2)};

    for (int i = 0; i < 17; i++) begin
      unit_valid = vecs[i].valid;
      bus_ready  = vecs[i].ready;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(unit_ready), 64'(vecs[i].exp_ur));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 64'(bus_valid), 64'(vecs[i].exp_bv));
      chk($sformatf("v%0d_unit", i), 64'(bus_unit), 64'(vecs[i].exp_unit));
      chk($sformatf("v%0d_result", i), 64'(bus_result), 64'(vecs[i].exp_res));
      chk($sformatf("v%0d_meta", i), 64'({bus_rs_id, bus_reg_addr, 7'(bus_cr0_xer)}),
          64'({5'(int'(vecs[i].exp_unit) + 1), 5'(int'(vecs[i].exp_unit) + 8),
               cx_of(int'(vecs[i].exp_unit))}));
    end

    // Mid-cycle asynchronous reset with a result in the slot.
    unit_valid = 4'b0111;
    bus_ready  = 1'b0;
    #2;
    chk("pre_async_valid", 64'(bus_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_valid", 64'(bus_valid), 64'd0);
    chk("async_result", 64'(bus_result), 64'd0);
    chk("async_unit", 64'(bus_unit), 64'd0);
    chk("async_ready", 64'(unit_ready), 64'd0);
    #1;
    rst = 1'b1;
    bus_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(unit_ready), 64'b0001);
    @(posedge clk); #1;
    chk("post_rst_unit", 64'(bus_unit), 64'd0);
    chk("post_rst_valid", 64'(bus_valid), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/result_bus_arbiter.md
RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

Interface
REQ-001 Parameter UNITS, default 4: number of requesting functional units (e.g. div, mul, alu, load), with a legal range of 2..8.
REQ-002 Parameter RS_ID_WIDTH, default 5: width of the reservation-station id carried with each result.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 unit_valid  input  UNITS  per-unit result valid.
REQ-006 unit_ready  output  UNITS  per-unit result accepted.
REQ-007 unit_rs_id  input  UNITS x RS_ID_WIDTH  per-unit rs id.
REQ-008 unit_reg_addr  input  UNITS x 5  per-unit destination GPR.
REQ-009 unit_result  input  UNITS x 32  per-unit result value.
REQ-010 unit_cr0_xer  input  UNITS x cond_exception_t  per-unit CR0/XER status.
REQ-011 bus_valid  output  1  broadcast result valid.
REQ-012 bus_ready  input  1  downstream (register file / RS update) accepts the broadcast.
REQ-013 bus_rs_id  output  RS_ID_WIDTH  rs id of the broadcast.
REQ-014 bus_reg_addr  output  5  destination GPR of the broadcast.
REQ-015 bus_result  output  32  result of the broadcast.
REQ-016 bus_cr0_xer  output  cond_exception_t  CR0/XER status of the broadcast.
REQ-017 bus_unit  output  $clog2(UNITS)  index of the unit that produced the broadcast.

Function
REQ-018 Output stage is one register slot (bus_valid plus payload); slot is "free" when bus_valid=0 or (bus_valid & bus_ready).
REQ-019 Arbitration happens combinationally each cycle, and only when the slot is free; otherwise unit_ready is all zeros.
REQ-020 Arbitration is round-robin: search starts at index (last_grant+1) mod UNITS, and the first unit with unit_valid=1 wins.
REQ-021 Exactly zero or one unit_ready bit is set per cycle, and the set bit is the winner's; unit_ready[i]=1 is only allowed when unit_valid[i]=1.
REQ-022 A transfer from unit i occurs when unit_valid[i] & unit_ready[i]; on that edge the slot loads unit i's payload, bus_unit=i, bus_valid=1, last_grant=i.
REQ-023 Latency: a result accepted at edge N is presented on the bus from edge N until consumed, i.e. visible in cycle N+1.
REQ-024 If the slot is free and no unit is valid, bus_valid clears to 0 on the edge, and the payload and last_grant hold.
REQ-025 While bus_valid=1 and bus_ready=0, all bus_* outputs hold stable and last_grant holds.
REQ-026 Simultaneous consume and load (bus_valid & bus_ready & a transfer) replaces the slot in the same edge, giving full throughput of one result per cycle with no bubble.
REQ-027 Fairness: with all units continuously valid and bus_ready=1, grants cycle i, i+1, ..., wrapping UNITS-1 to 0, and no unit waits more than UNITS-1 transfers.
REQ-028 unit_valid is never required to be held by this block; a requester dropping valid before grant loses nothing already accepted.

Reset
REQ-029 On rst low, immediately and regardless of clk: bus_valid=0, bus_rs_id=0, bus_reg_addr=0, bus_result=0, bus_cr0_xer=0, bus_unit=0, last_grant=UNITS-1 (so unit 0 has first priority).
REQ-030 While rst is low, unit_ready is all zeros, and a result held in the slot when reset asserts is discarded.
REQ-031 After rst deasserts, the first arbitration is allowed on the first rising edge.

Verification
REQ-032 Scenario: reset, then unit 2 alone valid with result 0xDEADBEEF, rs_id 3, reg 7, and bus_ready=1 -> unit_ready=0b0100 that cycle; next cycle bus_valid=1, bus_result=0xDEADBEEF, bus_rs_id=3, bus_reg_addr=7, bus_unit=2.
REQ-033 Scenario: all 4 units valid continuously after reset with bus_ready=1 -> grant order 0,1,2,3,0,1 and bus_valid stays 1 every cycle from cycle 1.
REQ-034 Scenario: bus holding unit 1's result, bus_ready=0 for 3 cycles, units 0 and 3 valid -> unit_ready=0 and bus_* stable for 3 cycles; when bus_ready=1, unit 3 is granted (search starts at 2).
REQ-035 Scenario: last_grant=3 and only unit 0 valid -> wrap-around grant to unit 0, and bus_unit=0 next cycle.
REQ-036 Scenario: rst pulsed low mid-cycle while bus_valid=1 -> bus_valid=0 asynchronously before the next edge; after release, unit 0 wins a 0/1/2 tie.
REQ-037 Scenario: bus_valid=1, bus_ready=1, no unit valid -> bus_valid=0 next cycle, and bus_result holds its previous value.
